inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port redirect_valid  input  1  branch/jump/trap redirect request.
REQ-005 SHALL have port redirect_pc  input  32  redirect target.
REQ-006 SHALL have port if_id_stall  input  1  downstream IF/ID register is holding.
REQ-007 SHALL have port imem_req  output  1  fetch request valid.
REQ-008 SHALL have port imem_addr  output  32  fetch address.
REQ-009 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-010 SHALL have port imem_rvalid  input  1  response valid.
REQ-011 SHALL have port imem_rdata  input  32  response instruction word.
REQ-012 SHALL have port imem_err  input  1  response bus error, qualified by imem_rvalid.
REQ-013 SHALL have port if_valid  output  1  if_pc/if_inst hold a real instruction.
REQ-014 SHALL have port if_pc  output  32  PC of presented instruction.
REQ-015 SHALL have port if_inst  output  35  {bus_err, misaligned, 1'b0, instr[31:0]}.

Function
REQ-016 SHALL keep a fetch PC, a 2-entry FIFO of {pc, inst35} and one outstanding-request flag.
REQ-017 SHALL have states FETCH (normal) and HALT (after error); HALT exits only on redirect_valid, to FETCH.
REQ-018 SHALL assert imem_req iff state=FETCH, no outstanding request, FIFO count+outstanding<2 and redirect_valid=0; imem_addr = fetch PC.
REQ-019 SHALL, on imem_req&imem_gnt, latch request PC, set outstanding, and add 4 to the fetch PC (32-bit wrap).
REQ-020 SHALL, on imem_rvalid with no drop pending, push {pc=request PC, inst={imem_err,2'b00,imem_rdata}} and clear outstanding.
REQ-021 SHALL, on an imem_err response, push inst field {1'b1,2'b00,32'h13} and enter HALT.
REQ-022 SHALL present the FIFO head on if_valid/if_pc/if_inst when non-empty; when empty: if_valid=0, if_pc=0, if_inst=35'h13.
REQ-023 SHALL pop the head each cycle if_id_stall=0 and FIFO non-empty; push and pop in the same cycle are allowed.
REQ-024 SHALL give a latency of grant cycle N, rvalid earliest N+1, if_valid earliest N+2.
REQ-025 SHALL, on redirect_valid, next cycle: fetch PC=redirect_pc, FIFO empty, state=FETCH, regardless of if_id_stall.
REQ-026 SHALL, on redirect_valid while outstanding and no same-cycle rvalid, set drop; the next rvalid is discarded and clears drop and outstanding.
REQ-027 SHALL discard a response arriving in the same cycle as redirect_valid and clear outstanding.
REQ-028 SHALL ignore imem_rvalid when nothing is outstanding.

Reset
REQ-029 SHALL, while rst=1, force fetch PC=RESET_PC, FIFO empty, outstanding=0, drop=0, state=FETCH, imem_req=0, if_valid=0, if_pc=0, if_inst=35'h13.
REQ-030 SHALL issue the first request in the first cycle after rst deasserts.
REQ-031 SHALL ignore any response to a request issued before a reset.

Configuration
REQ-032 SHALL provide macro IF_MISALIGN_CHK_EN.
REQ-033 SHALL, with IF_MISALIGN_CHK_EN defined, treat redirect_pc[1:0]!=0 as follows: no request issued; push one entry {pc=redirect_pc, inst={1'b0,1'b1,1'b0,32'h13}}; enter HALT.
REQ-034 SHALL, without IF_MISALIGN_CHK_EN, clear redirect_pc[1:0] to 2'b00 and leave if_inst[33] always 0.

Verification
REQ-035 SHALL test reset release with RESET_PC=0, zero-wait memory -> imem_addr 0,4,8 on consecutive grants; if_pc 0 valid two cycles after first grant.
REQ-036 SHALL test if_id_stall=1 for 5 cycles -> FIFO fills to 2, imem_req=0, if_pc/if_inst held; on release, pops in order with no loss.
REQ-037 SHALL test redirect to 0x100 with a 3-cycle outstanding response -> late response dropped; next if_pc=0x100.
REQ-038 SHALL test imem_err on the fetch at 0x8 -> if_inst=35'h4_0000_0013 with if_pc=8; no further imem_req until redirect.
REQ-039 SHALL test redirect to 0x102 with IF_MISALIGN_CHK_EN -> if_inst[33]=1, if_pc=0x102, HALT; without it -> fetch at 0x100.
REQ-040 SHALL test rst asserted mid-response -> outputs reset within the same cycle; restart at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch front end
//
// Keeps the fetch PC and drives one-at-a-time requests onto the instruction
// memory bus. Each response is written into a 2-entry FIFO of {pc, inst}, and
// the FIFO head is presented to the IF/ID register. A redirect flushes the
// FIFO and restarts fetch at the target. A response that belongs to the
// pre-redirect stream is dropped. A bus error pushes a marked NOP and halts
// fetch until the next redirect.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   redirect_valid/_pc        branch/jump/trap redirect request and target
//   if_id_stall               IF/ID holding; FIFO head is not consumed
//   imem_req/_addr/_gnt       fetch request handshake
//   imem_rvalid/_rdata/_err   fetch response
//   if_valid/_pc/_inst        presented instruction;
//                             if_inst = {bus_err, misaligned, 1'b0, instr}
//
// Configuration
//   IF_MISALIGN_CHK_EN  when defined, a redirect to a target that is not
//                       word-aligned pushes a marked NOP (if_inst[33]=1)
//                       and halts. When undefined, the target's low two
//                       bits are cleared instead.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [34:0] if_inst
);

  localparam logic [0:0]  ST_FETCH = 1'b0;
  localparam logic [0:0]  ST_HALT  = 1'b1;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [34:0] NOP_INST = {3'b000, NOP};

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        outstanding_q, outstanding_d;
  logic        drop_q, drop_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] fifo_pc_q   [2];
  logic [34:0] fifo_inst_q [2];

  logic        grant;
  logic        pop;
  logic        push;
  logic        push_idx;
  logic [31:0] push_pc;
  logic [34:0] push_inst;
  logic [31:0] redirect_tgt;

  // Only one request may be in flight. An in-flight request also reserves a
  // FIFO slot, so a response always has room to land.
  assign imem_req = !rst && (state_q == ST_FETCH) && !outstanding_q
                    && ((count_q + {1'b0, outstanding_q}) < 2'd2)
                    && !redirect_valid;
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  assign pop       = !if_id_stall && (count_q != 2'd0);

`ifdef IF_MISALIGN_CHK_EN
  assign redirect_tgt = redirect_pc;
`else
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  // NOTE: every signal gets a default at the top so that no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    push          = 1'b0;
    push_idx      = wr_ptr_q;
    push_pc       = req_pc_q;
    push_inst     = {imem_err, 2'b00, imem_rdata};

    if (redirect_valid) begin
      // Flush and restart. A response in the same cycle is discarded. If the
      // response has not arrived yet, it is marked for dropping.
      pc_d     = redirect_tgt;
      state_d  = ST_FETCH;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      if (outstanding_q) begin
        if (imem_rvalid) begin
          outstanding_d = 1'b0;
          drop_d        = 1'b0;
        end else begin
          drop_d = 1'b1;
        end
      end
`ifdef IF_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        push      = 1'b1;
        push_idx  = 1'b0;
        push_pc   = redirect_pc;
        push_inst = {1'b0, 1'b1, 1'b0, NOP};
        wr_ptr_d  = 1'b1;
        count_d   = 2'd1;
        state_d   = ST_HALT;
      end
`endif
    end else begin
      if (grant) begin
        req_pc_d      = pc_q;
        outstanding_d = 1'b1;
        pc_d          = pc_q + 32'd4;
      end
      // A grant and a response cannot land in the same cycle. The grant
      // requires outstanding_q=0, and the response requires outstanding_q=1.
      if (imem_rvalid && outstanding_q) begin
        outstanding_d = 1'b0;
        if (drop_q) begin
          drop_d = 1'b0;
        end else begin
          push = 1'b1;
          if (imem_err) begin
            push_inst = {1'b1, 2'b00, NOP};
            state_d   = ST_HALT;
          end
        end
      end
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: state registers use non-blocking assignments, so every always_ff
  // block samples the pre-edge values no matter what order the blocks run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      req_pc_q      <= 32'h0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // NOTE: the FIFO storage has no reset. count_q gates every read, so stale
  // contents are never visible, and leaving the reset out keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[push_idx]   <= push_pc;
      fifo_inst_q[push_idx] <= push_inst;
    end
  end

  assign if_valid = (count_q != 2'd0);
  assign if_pc    = if_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
  assign if_inst  = if_valid ? fifo_inst_q[rd_ptr_q] : NOP_INST;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch
//
// A transaction-level reference model (queue of presented entries, fetch PC,
// in-flight and drop flags) and a small memory responder with random latency
// run alongside the DUT. All outputs are compared against the model every
// cycle. Directed scenarios come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [34:0] if_inst;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_stall    (if_id_stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [34:0] inst;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_drop;
  bit          m_halt;

  // Memory responder state and knobs
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;
  bit          mem_err;
  int          gnt_pct   = 100;
  int          lat_min   = 0;
  int          lat_max   = 0;
  int          err_pct   = 0;
  int          spur_pct  = 0;
  bit          err_at_en = 0;
  logic [31:0] err_at    = 32'h0;

  logic [31:0] gnt_log[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] get_gnt(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = RESET_PC;
    m_req_pc = 32'h0;
    m_out    = 0;
    m_drop   = 0;
    m_halt   = 0;
    mem_pend = 0;
  endtask

  // One clock cycle. Inputs are driven at the negedge. Outputs are compared
  // 1ns later against the model. The model advances after the posedge.
  task automatic tick(input logic r, input logic rdv, input logic [31:0] rpc, input logic st);
    logic        g, v, e, exp_req, do_gnt, do_rsp;
    logic [31:0] d;
    ent_t        head;
    @(negedge clk);
    g = ($urandom_range(0, 99) < gnt_pct);
    if (mem_pend) begin
      v = (mem_wait == 0);
      d = data_of(mem_addr);
      e = v && mem_err;
    end else begin
      v = ($urandom_range(0, 99) < spur_pct);
      d = $urandom;
      e = v && ($urandom_range(0, 1) == 1);
    end
    rst = r; redirect_valid = rdv; redirect_pc = rpc; if_id_stall = st;
    imem_gnt = g; imem_rvalid = v; imem_rdata = d; imem_err = e;
    if (r) model_reset();
    #1;
    exp_req = !r && !m_halt && !m_out && ((m_q.size() + int'(m_out)) < 2) && !rdv;
    if (m_q.size() != 0) head = m_q[0];
    else head = '{pc: 32'h0, inst: 35'h13};
    check("imem_req", imem_req, exp_req);
    check("imem_addr", imem_addr, m_pc);
    check("if_valid", if_valid, m_q.size() != 0);
    check("if_pc", if_pc, head.pc);
    check("if_inst", if_inst, head.inst);
    if (imem_req && g) gnt_log.push_back(imem_addr);
    @(posedge clk);
    if (r) return;
    do_gnt = exp_req && g;
    do_rsp = v && m_out;
    if (mem_pend) begin
      if (v) mem_pend = 0;
      else mem_wait--;
    end
    if (do_gnt) begin
      mem_pend = 1;
      mem_addr = m_pc;
      mem_wait = $urandom_range(lat_min, lat_max);
      mem_err  = (err_at_en && m_pc == err_at) || ($urandom_range(0, 99) < err_pct);
    end
    if (rdv) begin
      m_q.delete();
      m_halt = 0;
      if (m_out) begin
        if (v) begin m_out = 0; m_drop = 0; end
        else m_drop = 1;
      end
`ifdef IF_MISALIGN_CHK_EN
      m_pc = rpc;
      if (rpc[1:0] != 2'b00) begin
        m_q.push_back('{pc: rpc, inst: {3'b010, 32'h13}});
        m_halt = 1;
      end
`else
      m_pc = rpc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (!st && m_q.size() != 0) void'(m_q.pop_front());
      if (do_gnt) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        m_out    = 1;
      end
      if (do_rsp) begin
        m_out = 0;
        if (m_drop) m_drop = 0;
        else if (e) begin
          m_q.push_back('{pc: m_req_pc, inst: {1'b1, 2'b00, 32'h13}});
          m_halt = 1;
        end else begin
          m_q.push_back('{pc: m_req_pc, inst: {3'b000, d}});
        end
      end
    end
  endtask

  task automatic do_reset();
    tick(1, 0, 32'h0, 0);
    tick(1, 0, 32'h0, 0);
    gnt_log.delete();
  endtask

  task automatic wait_head(input logic [31:0] pc, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(0, 0, 32'h0, 0);
      #1;
      seen = if_valid && (if_pc == pc);
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    logic [34:0] inst_v;
    logic [31:0] rpc;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; if_id_stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
    model_reset();

    // Reset release, zero-wait memory
    do_reset();
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", if_valid, 1'b0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 35'h13);
    check("rst_addr", imem_addr, RESET_PC);
    tick(0, 0, 32'h0, 0);
    tick(0, 0, 32'h0, 0);
    #1;
    check("t1_valid_n2", if_valid, 1'b1);
    check("t1_pc_n2", if_pc, 32'h0);
    check("t1_inst_n2", if_inst, {3'b000, data_of(32'h0)});
    for (int i = 0; i < 4; i++) tick(0, 0, 32'h0, 0);
    check("t1_gnt0", get_gnt(0), 32'h0);
    check("t1_gnt1", get_gnt(1), 32'h4);
    check("t1_gnt2", get_gnt(2), 32'h8);

    // Stall fills FIFO, release drains in order
    do_reset();
    for (int i = 0; i < 5; i++) tick(0, 0, 32'h0, 1);
    #1;
    check("t2_full_req", imem_req, 1'b0);
    check("t2_held_valid", if_valid, 1'b1);
    check("t2_held_pc", if_pc, 32'h0);
    check("t2_held_inst", if_inst, {3'b000, data_of(32'h0)});
    tick(0, 0, 32'h0, 0);
    #1;
    check("t2_pop1_pc", if_pc, 32'h4);
    check("t2_pop1_inst", if_inst, {3'b000, data_of(32'h4)});
    tick(0, 0, 32'h0, 0);
    tick(0, 0, 32'h0, 0);
    #1;
    check("t2_next_valid", if_valid, 1'b1);
    check("t2_next_pc", if_pc, 32'h8);

    // Redirect while a slow response is outstanding
    lat_min = 3; lat_max = 3;
    do_reset();
    tick(0, 0, 32'h0, 0);
    lat_min = 0; lat_max = 0;
    tick(0, 1, 32'h100, 0);
    wait_head(32'h100, "t3_first_after_redirect");
    check("t3_gnt_after_redirect", get_gnt(1), 32'h100);

    // Bus error at 0x8 halts until redirect
    err_at_en = 1; err_at = 32'h8;
    do_reset();
    wait_head(32'h8, "t4_reach_8");
    check("t4_err_inst", if_inst, 35'h4_0000_0013);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 32'h0, 0);
      #1;
      check("t4_halt_no_req", imem_req, 1'b0);
    end
    err_at_en = 0;
    gnt_log.delete();
    tick(0, 1, 32'h40, 0);
    tick(0, 0, 32'h0, 0);
    check("t4_resume_gnt", get_gnt(0), 32'h40);

    // Redirect to a misaligned target
    do_reset();
    tick(0, 0, 32'h0, 0);
    tick(0, 1, 32'h102, 0);
    gnt_log.delete();
`ifdef IF_MISALIGN_CHK_EN
    #1;
    inst_v = if_inst;
    check("t5_mis_valid", if_valid, 1'b1);
    check("t5_mis_pc", if_pc, 32'h102);
    check("t5_mis_bit", inst_v[33], 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 32'h0, 1);
      #1;
      check("t5_halt_no_req", imem_req, 1'b0);
    end
`else
    tick(0, 0, 32'h0, 0);
    check("t5_aligned_gnt", get_gnt(0), 32'h100);
    wait_head(32'h100, "t5_aligned_head");
    inst_v = if_inst;
    check("t5_no_mis_bit", inst_v[33], 1'b0);
`endif

    // Asynchronous reset in the middle of a response
    lat_min = 2; lat_max = 2;
    do_reset();
    for (int i = 0; i < 5; i++) tick(0, 0, 32'h0, 1);
    #1;
    check("t6_pre_valid", if_valid, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_req", imem_req, 1'b0);
    check("t6_rst_valid", if_valid, 1'b0);
    check("t6_rst_pc", if_pc, 32'h0);
    check("t6_rst_inst", if_inst, 35'h13);
    check("t6_rst_addr", imem_addr, RESET_PC);
    tick(1, 0, 32'h0, 0);
    gnt_log.delete();
    lat_min = 0; lat_max = 0;
    tick(0, 0, 32'h0, 0);
    check("t6_restart_gnt", get_gnt(0), RESET_PC);

    // Randomized run
    gnt_pct = 70; lat_min = 0; lat_max = 3; err_pct = 3; spur_pct = 10;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 5, rpc,
           $urandom_range(0, 99) < 30);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
